// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: lane modes, legal shift widths and shifter state encoding.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package qspi_pkg;

  // Lane modes, shared with the shift-width decoder.
  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_DUAL   = 2'd1,
    MODE_QUAD   = 2'd2
  } mode_t;

  // Bits shifted per SCLK strobe.
  localparam logic [2:0] W1 = 3'd1;
  localparam logic [2:0] W2 = 3'd2;
  localparam logic [2:0] W4 = 3'd4;

  // Transmit shifter states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Only 2 and 4 are taken at face value; anything else falls back to single lane.
  function automatic logic [2:0] legal_width(input logic [2:0] sw);
    case (sw)
      W2:      return W2;
      W4:      return W4;
      default: return W1;
    endcase
  endfunction

endpackage

// File: rtl/qspi_tx_shifter_if.sv
// Word handshake between the command sequencer (master) and the transmit shifter (slave).
// Latency: n/a (signal bundle only).
// Backpressure: tx_ready low holds the word; the master keeps tx_data stable while tx_valid is high.
interface qspi_tx_shifter_if #(
  parameter int DATA_W = 8
) ();

  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/qspi_lane_mux.sv
// Maps the 4-bit shift-register window and the latched width onto IO lanes and enables.
// Latency: combinational; the parent registers the result.
// Backpressure: none. Build option QSPI_LSB_FIRST_EN selects the low-bit window ordering.
module qspi_lane_mux
  import qspi_pkg::*;
(
  input  logic [3:0] window,
  input  logic [2:0] w,
  output logic [3:0] lanes,
  output logic [3:0] oe
);

  // Select the lanes used by the current width; undriven lanes stay 0.
  always_comb begin
    lanes = '0;
    oe    = '0;
    case (w)
      W4: begin
        lanes = window;
        oe    = 4'b1111;
      end
      W2: begin
`ifdef QSPI_LSB_FIRST_EN
        lanes[1:0] = window[1:0];
`else
        lanes[1:0] = window[3:2];
`endif
        oe = 4'b0011;
      end
      default: begin
`ifdef QSPI_LSB_FIRST_EN
        lanes[0] = window[0];
`else
        lanes[0] = window[3];
`endif
        oe = 4'b0001;
      end
    endcase
  end

endmodule

// File: rtl/qspi_tx_shifter.sv
// QSPI parallel-to-serial transmit shifter: shifts a word out 1/2/4 bits per SCLK strobe.
// Latency: first group on IO one cycle after the load; done one cycle after the last strobe.
// Backpressure: tx_ready only in IDLE or on the last-group strobe (gapless back-to-back words).
// Build option QSPI_LSB_FIRST_EN: shift right and transmit the low bits first.
module qspi_tx_shifter
  import qspi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              shift_width,
  input  logic                    shift_en,
  qspi_tx_shifter_if.slave        tx,
  output logic [3:0]              io_out,
  output logic [3:0]              io_oe,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  sr, sr_nxt, sr_shift;
  logic [2:0]         w, w_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               last;
  logic               load;
  logic [3:0]         window;
  logic [3:0]         lanes;
  logic [3:0]         oe;

  // The last group leaves on this strobe: the shifter can take the next word now.
  assign last        = (state == SHIFT) && shift_en && (cnt == CNT_W'(w));
  assign tx.tx_ready = (state == IDLE) || last;
  assign load        = tx.tx_valid && tx.tx_ready;

`ifdef QSPI_LSB_FIRST_EN
  assign sr_shift = sr >> w;
  assign window   = sr_nxt[3:0];
`else
  assign sr_shift = sr << w;
  assign window   = sr_nxt[DATA_W-1 -: 4];
`endif

  // Next shifter contents; a load takes priority over any strobe in the same cycle.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    w_nxt     = w;
    cnt_nxt   = cnt;
    if (load) begin
      state_nxt = SHIFT;
      sr_nxt    = tx.tx_data;
      w_nxt     = legal_width(shift_width);
      cnt_nxt   = CNT_W'(DATA_W);
    end else if (last) begin
      state_nxt = IDLE;
      sr_nxt    = '0;
      cnt_nxt   = '0;
    end else if (state == SHIFT && shift_en) begin
      sr_nxt  = sr_shift;
      cnt_nxt = cnt - CNT_W'(w);
    end
  end

  qspi_lane_mux u_lane_mux (
    .window (window),
    .w      (w_nxt),
    .lanes  (lanes),
    .oe     (oe)
  );

  // Shifter state and registered IO: lanes reflect the group that will be on the wire next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sr     <= '0;
      w      <= '0;
      cnt    <= '0;
      io_out <= '0;
      io_oe  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      w     <= w_nxt;
      cnt   <= cnt_nxt;
      done  <= last;
      busy  <= (state_nxt == SHIFT);
      if (state_nxt == SHIFT) begin
        io_out <= lanes;
        io_oe  <= oe;
      end else begin
        io_out <= '0;
        io_oe  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_qspi_tx_shifter.sv
// Testbench for qspi_tx_shifter: directed scenarios plus randomized traffic against a group-queue model.
// Latency: n/a.
// Backpressure: upstream holds tx_valid/tx_data until the handshake completes.
module tb_qspi_tx_shifter;
  import qspi_pkg::*;

  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] shift_width = 3'd0;
  logic       shift_en = 1'b0;
  logic [3:0] io_out, io_oe;
  logic       busy, done;

  qspi_tx_shifter_if #(.DATA_W(DW)) tx_if ();

  qspi_tx_shifter #(.DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .shift_width (shift_width),
    .shift_en    (shift_en),
    .tx          (tx_if),
    .io_out      (io_out),
    .io_oe       (io_oe),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: queue of groups still to appear on the wire (front = currently driven).
  int unsigned mq[$];
  int unsigned m_w = 1;
  bit          m_done = 1'b0;

  // Observation helpers for directed scenarios.
  logic [31:0] cap;
  int          cap_pos;
  int          done_cnt;
  int          rdy_busy_cnt;
  bit          hs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned legal_w(input logic [2:0] sw);
    return (sw == 3'd2 || sw == 3'd4) ? int'(sw) : 1;
  endfunction

  // Split a word into the groups that go out, in wire order.
  task automatic model_load(input logic [DW-1:0] word, input int unsigned wv);
    int unsigned mask;
    mask = (1 << wv) - 1;
    mq.delete();
    for (int k = 0; k < DW / int'(wv); k++) begin
`ifdef QSPI_LSB_FIRST_EN
      mq.push_back((int'(word) >> (int'(wv) * k)) & mask);
`else
      mq.push_back((int'(word) >> (DW - int'(wv) * (k + 1))) & mask);
`endif
    end
    m_w = wv;
  endtask

  task automatic clear_obs();
    cap = '0;
    cap_pos = 0;
    done_cnt = 0;
    rdy_busy_cnt = 0;
  endtask

  // One clock: check tx_ready against the model, advance both, check registered outputs.
  task automatic step();
    bit          act, lst, rdy;
    logic [3:0]  grp;
    int          wv;
    #1;
    act = (mq.size() != 0);
    lst = act && shift_en && (mq.size() == 1);
    rdy = !act || lst;
    check_eq("tx_ready", {31'd0, tx_if.tx_ready}, {31'd0, rdy});
    if (act && tx_if.tx_ready) rdy_busy_cnt++;
    if (act && shift_en) begin
      grp = io_out & io_oe;
      wv  = $countones(io_oe);
`ifdef QSPI_LSB_FIRST_EN
      cap = cap | ({28'd0, grp} << cap_pos);
      cap_pos += wv;
`else
      cap = (cap << wv) | {28'd0, grp};
`endif
    end
    hs = 1'b0;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_done = 1'b0;
    end else begin
      m_done = lst;
      if (tx_if.tx_valid && rdy) begin
        hs = 1'b1;
        model_load(tx_if.tx_data, legal_w(shift_width));
      end else if (act && shift_en) begin
        void'(mq.pop_front());
      end
    end
    #1;
    check_eq("io_out", {28'd0, io_out}, (mq.size() != 0) ? mq[0] : 32'd0);
    check_eq("io_oe", {28'd0, io_oe}, (mq.size() != 0) ? ((32'd1 << m_w) - 1) : 32'd0);
    check_eq("busy", {31'd0, busy}, {31'd0, (mq.size() != 0)});
    check_eq("done", {31'd0, done}, {31'd0, m_done});
    if (done) done_cnt++;
  endtask

  task automatic send_load(input logic [DW-1:0] data, input logic [2:0] sw);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = data;
    shift_width    = sw;
    shift_en       = 1'b0;
    step();
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      shift_en = 1'b0;
      repeat (gap) step();
      shift_en = 1'b1;
      step();
    end
    shift_en = 1'b0;
  endtask

  initial begin
    bit pending;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    clear_obs();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_io_oe", {28'd0, io_oe}, 32'd0);
    check_eq("rst_io_out", {28'd0, io_out}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_ready", {31'd0, tx_if.tx_ready}, 32'd1);
    reset = 1'b0;

    // Single lane 0xA5.
    clear_obs();
    send_load(8'hA5, 3'd1);
    strobes(8, 1);
    repeat (2) step();
    check_eq("single_seq", cap, 32'hA5);
    check_eq("single_done", done_cnt, 1);

    // Dual lane 0xA5.
    clear_obs();
    send_load(8'hA5, 3'd2);
    strobes(4, 2);
    repeat (2) step();
    check_eq("dual_seq", cap, 32'hA5);
    check_eq("dual_done", done_cnt, 1);

    // Quad back-to-back 0xA5, 0x3C with tx_valid held.
    clear_obs();
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'hA5;
    shift_width    = 3'd4;
    step();
    tx_if.tx_data  = 8'h3C;
    strobes(2, 0);
    tx_if.tx_valid = 1'b0;
    strobes(2, 0);
    repeat (2) step();
    check_eq("quad_b2b_seq", cap, 32'hA53C);
    check_eq("quad_b2b_done", done_cnt, 2);
    check_eq("quad_b2b_ready", rdy_busy_cnt, 2);

    // Quad load, width switched to 1 mid-word.
    clear_obs();
    send_load(8'hA5, 3'd4);
    strobes(1, 0);
    shift_width = 3'd1;
    strobes(1, 1);
    repeat (2) step();
    check_eq("quad_wchg_seq", cap, 32'hA5);
    check_eq("quad_wchg_done", done_cnt, 1);

    // Reset mid-word, then a clean word.
    clear_obs();
    send_load(8'hFF, 3'd1);
    strobes(3, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_oe", {28'd0, io_oe}, 32'd0);
    step();
    check_eq("midrst_done", done_cnt, 0);
    clear_obs();
    send_load(8'h81, 3'd1);
    strobes(8, 0);
    repeat (2) step();
    check_eq("after_rst_seq", cap, 32'h81);
    check_eq("after_rst_done", done_cnt, 1);

    // Illegal width 3 behaves as single lane.
    clear_obs();
    send_load(8'hC0, 3'd3);
    strobes(8, 1);
    repeat (2) step();
    check_eq("illegal_w_seq", cap, 32'hC0);
    check_eq("illegal_w_done", done_cnt, 1);

    // Randomized traffic: random widths, strobe spacing, back-to-back words, occasional reset.
    pending = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pending && ($urandom_range(0, 3) == 0)) begin
        pending        = 1'b1;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = DW'($urandom);
      end
      shift_width = 3'($urandom_range(0, 7));
      shift_en    = ($urandom_range(0, 2) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      step();
      if (hs) begin
        pending        = 1'b0;
        tx_if.tx_valid = 1'b0;
      end
    end
    reset          = 1'b0;
    tx_if.tx_valid = 1'b0;
    shift_en       = 1'b1;
    repeat (40) step();
    check_eq("drain_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
